rx_data_sampler: RTL
====================

// Module: rx_data_sampler
// PURPOSE
// - Oversampling front end of the UART RX path; sits directly upstream of parity_check.
// - Synchronises raw rx_in and runs the per-bit edge counter and frame bit counter.
// - Takes 3 samples around mid-bit, majority-votes them and emits one sampled_data bit
//   plus a 1-cycle sampled_valid strobe per UART bit.
// - Output feeds parity_check, the deserializer and the stop/start checkers.
// PARAMETERS
// - PRESCALE_W  6  width of the prescale input and edge_cnt; legal prescale values are 8, 16, 32.
// - BIT_CNT_W   4  width of bit_cnt; counts bits within a frame.
// PORTS
// clk            in   1            single system clock, oversampling rate (prescale x baud)
// rst            in   1            synchronous, active-high reset
// rx_in          in   1            raw serial line, asynchronous, idle high
// prescale       in   PRESCALE_W   oversampling ratio; latched on the sample_enable rising edge
// sample_enable  in   1            high for the whole frame, from the RX FSM
// sampled_data   out  1            majority-voted bit value
// sampled_valid  out  1            1-cycle strobe: sampled_data is new
// edge_cnt       out  PRESCALE_W   position within current bit, 0..P-1
// bit_cnt        out  BIT_CNT_W    index of current bit within frame
// bit_done       out  1            1-cycle strobe when edge_cnt wraps P-1 -> 0
// prescale_err   out  1            latched prescale not in {8,16,32}
// BEHAVIOUR
// - Reset values:
//   - sampled_data=1, sampled_valid=0, edge_cnt=0, bit_cnt=0, bit_done=0, prescale_err=0.
//   - Both sync flops = 1 (idle line).
// - Synchroniser: 2-flop on rx_in; rx_s lags rx_in by 2 clk. All sampling uses rx_s only.
// - Prescale latch:
//   - P_lat loads from prescale on the cycle sample_enable goes 0->1.
//   - prescale changes mid-frame are ignored.
//   - prescale_err = (P_lat not in {8,16,32}), updated with P_lat. While it is set,
//     counters hold at 0 and no strobes fire.
// - Counting (sample_enable=1, no error):
//   - edge_cnt increments every clk.
//   - At edge_cnt==P-1 it wraps to 0, bit_done=1 for that cycle, and bit_cnt increments.
//   - bit_cnt wraps modulo 2^BIT_CNT_W; the FSM deasserts enable before then.
// - Sampling: with H=P/2, capture rx_s into s0,s1,s2 at edge_cnt == H-2, H-1, H
//   (P=8: 2,3,4; P=16: 6,7,8).
// - Vote: at edge_cnt==H+1, sampled_data <= (s0&s1)|(s1&s2)|(s0&s2) and sampled_valid=1
//   for exactly that one cycle. One strobe per bit.
// - Disable: sample_enable=0 means that next clk:
//   - edge_cnt=0, bit_cnt=0, sampled_valid=0, bit_done=0;
//   - sampled_data holds its last value; s0..s2 are cleared to 1.
// - Enable dropping mid-bit: no strobe for the partial bit. Re-enable restarts at edge_cnt=0.
// - Simultaneous events: bit_done (edge_cnt P-1) and sampled_valid (H+1) never coincide for
//   legal P. Disable takes priority over every count and strobe.
// - rst asserted mid-frame: all state returns to reset values on that clk edge,
//   regardless of sample_enable.
// STRUCTURE
// - Shared uart_rx_pkg: legal prescale constants (PRESC_8/16/32), IDLE_LEVEL=1'b1,
//   and a function majority3().
// - One sub-module: rx_sync2 (2-flop synchroniser, reset value parameterised).
// - Counters, sample registers and vote stay in this module. No FSM beyond the enable gating.
// TESTING
// - Directed scenarios, all with P=8 unless stated:
// 1. Reset sequence: rst high for 3 clk with rx_in=0 -> sampled_data=1, all counts 0,
//    sync flops 1.
// 2. Clean byte 0xA5 LSB-first, 8 clk/bit, enable held -> 8 strobes at edge_cnt=5.
//    Data sequence 1,0,1,0,0,1,0,1; bit_done every 8 clk.
// 3. Glitch: bit=1 with rx_s=0 only at edge_cnt=3 -> sampled_data=1.
//    Two low samples (3,4) -> 0.
// 4. P=16 frame -> samples at edge_cnt 6,7,8; strobe at 9; bit_done period 16 clk.
// 5. prescale=12 on enable rise -> prescale_err=1, edge_cnt stays 0, no strobes.
//    Change prescale to 16 mid-frame -> no effect.
// 6. sample_enable dropped at edge_cnt=3 of bit 2 -> next clk counts 0, no strobe.
//    rst at edge_cnt=4 -> all outputs at reset values.

Source files
------------

// File: rtl/rx_data_sampler_pkg.sv
// Shared UART RX constants: legal oversampling ratios, idle line level and the
// three-sample majority vote used by the data sampler.
package rx_data_sampler_pkg;

   localparam int PKG_PRESCALE_W = 6;
   localparam int PKG_BIT_CNT_W  = 4;

   localparam logic [5:0] PRESC_8  = 6'd8;
   localparam logic [5:0] PRESC_16 = 6'd16;
   localparam logic [5:0] PRESC_32 = 6'd32;

   localparam logic IDLE_LEVEL = 1'b1;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (b & c) | (a & c);
   endfunction

endpackage

// File: rtl/rx_data_sampler_if.sv
// Bus between the RX FSM / line and the oversampling data sampler.
interface rx_data_sampler_if
   import rx_data_sampler_pkg::*;
#(
   parameter int PRESCALE_W = PKG_PRESCALE_W,
   parameter int BIT_CNT_W  = PKG_BIT_CNT_W
);
   logic                  rx_in;
   logic [PRESCALE_W-1:0] prescale;
   logic                  sample_enable;
   logic                  sampled_data;
   logic                  sampled_valid;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic                  bit_done;
   logic                  prescale_err;

   modport master (
      output rx_in, prescale, sample_enable,
      input  sampled_data, sampled_valid, edge_cnt, bit_cnt, bit_done, prescale_err
   );

   modport slave (
      input  rx_in, prescale, sample_enable,
      output sampled_data, sampled_valid, edge_cnt, bit_cnt, bit_done, prescale_err
   );
endinterface

// File: rtl/rx_data_sampler_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; reset level selectable.
module rx_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta_q;
   logic meta_d;
   logic sync_q;
   logic sync_d;

   // next-state of the two-stage pipeline
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // synchroniser flops
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;
endmodule

// File: rtl/rx_data_sampler.sv
// UART RX oversampling front end: edge/bit counters, three mid-bit samples and a
// majority vote that yields one sampled_data bit with a one-cycle valid strobe per bit.
module rx_data_sampler
   import rx_data_sampler_pkg::*;
#(
   parameter int PRESCALE_W = PKG_PRESCALE_W,
   parameter int BIT_CNT_W  = PKG_BIT_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   rx_data_sampler_if.slave   bus
);
   logic                  rx_s;
   logic                  en_q,    en_d;
   logic [PRESCALE_W-1:0] plat_q,  plat_d;
   logic                  err_q,   err_d;
   logic [PRESCALE_W-1:0] edge_q,  edge_d;
   logic [BIT_CNT_W-1:0]  bit_q,   bit_d;
   logic                  s0_q,    s0_d;
   logic                  s1_q,    s1_d;
   logic                  s2_q,    s2_d;
   logic                  data_q,  data_d;
   logic                  valid_q, valid_d;
   logic                  done_q,  done_d;

   logic                  rise_s;
   logic [PRESCALE_W-1:0] p_eff_s;
   logic                  err_eff_s;
   logic [PRESCALE_W-1:0] half_s;
   logic [PRESCALE_W-1:0] pm1_s;
   logic                  wrap_s;
   logic [PRESCALE_W-1:0] edge_next_s;

   rx_sync2 #(.RST_VAL(IDLE_LEVEL)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.rx_in),
      .q   (rx_s)
   );

   // prescale is taken live on the enable rising cycle so the first bit already counts with it
   always_comb begin
      rise_s    = bus.sample_enable & ~en_q;
      p_eff_s   = rise_s ? bus.prescale : plat_q;
      err_eff_s = rise_s ? ~((bus.prescale == PRESCALE_W'(PRESC_8))  ||
                             (bus.prescale == PRESCALE_W'(PRESC_16)) ||
                             (bus.prescale == PRESCALE_W'(PRESC_32)))
                         : err_q;
      half_s      = p_eff_s >> 1;
      pm1_s       = p_eff_s - PRESCALE_W'(1'b1);
      wrap_s      = (edge_q == pm1_s);
      edge_next_s = wrap_s ? PRESCALE_W'(1'b0) : edge_q + PRESCALE_W'(1'b1);

      en_d    = bus.sample_enable;
      plat_d  = p_eff_s;
      err_d   = err_eff_s;
      edge_d  = edge_q;
      bit_d   = bit_q;
      s0_d    = s0_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      data_d  = data_q;
      valid_d = 1'b0;
      done_d  = 1'b0;

      if (!bus.sample_enable) begin
         edge_d = PRESCALE_W'(1'b0);
         bit_d  = BIT_CNT_W'(1'b0);
         s0_d   = IDLE_LEVEL;
         s1_d   = IDLE_LEVEL;
         s2_d   = IDLE_LEVEL;
      end else if (err_eff_s) begin
         edge_d = PRESCALE_W'(1'b0);
         bit_d  = BIT_CNT_W'(1'b0);
      end else begin
         edge_d  = edge_next_s;
         bit_d   = wrap_s ? bit_q + BIT_CNT_W'(1'b1) : bit_q;
         done_d  = (edge_next_s == pm1_s);
         valid_d = (edge_next_s == half_s + PRESCALE_W'(1'b1));
         s0_d    = (edge_q == half_s - PRESCALE_W'(2'd2)) ? rx_s : s0_q;
         s1_d    = (edge_q == half_s - PRESCALE_W'(1'b1)) ? rx_s : s1_q;
         s2_d    = (edge_q == half_s) ? rx_s : s2_q;
         // third sample is still on rx_s in the cycle the vote is registered
         data_d  = valid_d ? majority3(s0_q, s1_q, rx_s) : data_q;
      end
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q    <= 1'b0;
         plat_q  <= PRESCALE_W'(PRESC_8);
         err_q   <= 1'b0;
         edge_q  <= PRESCALE_W'(1'b0);
         bit_q   <= BIT_CNT_W'(1'b0);
         s0_q    <= IDLE_LEVEL;
         s1_q    <= IDLE_LEVEL;
         s2_q    <= IDLE_LEVEL;
         data_q  <= IDLE_LEVEL;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         en_q    <= en_d;
         plat_q  <= plat_d;
         err_q   <= err_d;
         edge_q  <= edge_d;
         bit_q   <= bit_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign bus.sampled_data  = data_q;
   assign bus.sampled_valid = valid_q;
   assign bus.edge_cnt      = edge_q;
   assign bus.bit_cnt       = bit_q;
   assign bus.bit_done      = done_q;
   assign bus.prescale_err  = err_q;
endmodule
